// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I mnemonic codes, opcode/funct constants, the canonical NOP,
// encoder FSM state type and small decode helpers shared by the encoder.
package rv32_pkg;

   // Mnemonic codes carried on req_op; values 29-31 are illegal
   typedef enum logic [4:0] {
      OP_ADD   = 5'd0,  OP_SUB,   OP_SLL,   OP_SLT,   OP_SLTU,
      OP_XOR,  OP_SRL,  OP_SRA,   OP_OR,    OP_AND,
      OP_ADDI  = 5'd10, OP_SLTI,  OP_SLTIU, OP_XORI,  OP_ORI,
      OP_ANDI, OP_SLLI, OP_SRLI,  OP_SRAI,
      OP_LW    = 5'd19, OP_SW,
      OP_BEQ   = 5'd21, OP_BNE,   OP_BLT,   OP_BLTU,
      OP_JAL   = 5'd25, OP_JALR,  OP_LUI,   OP_AUIPC
   } op_e;

   // Instruction format selected by the packer
   typedef enum logic [2:0] {
      FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U, FMT_BAD
   } fmt_e;

   // Encoder FSM state, also exported on the debug port
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_NOP   = 2'd1,
      ST_INSTR = 2'd2
   } enc_state_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_W    = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BLTU = 3'b110;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   // True when the op reads rs1 (R, I incl. shifts, LW, JALR, S, B)
   function automatic logic op_reads_rs1(input logic [4:0] op);
      return (op <= OP_AND) ||
             ((op >= OP_ADDI) && (op <= OP_SW)) ||
             ((op >= OP_BEQ) && (op <= OP_BLTU)) ||
             (op == OP_JALR);
   endfunction

   // True when the op reads rs2 (R, S, B)
   function automatic logic op_reads_rs2(input logic [4:0] op);
      return (op <= OP_AND) || (op == OP_SW) ||
             ((op >= OP_BEQ) && (op <= OP_BLTU));
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request channel into the encoder and write channel out
// to instruction memory.
//
// Both channels use valid/ready: a transfer happens on a rising edge where
// valid && ready are both high; once valid is raised the payload is held
// stable until that transfer (or a flush/reset drops it).
interface instr_encoder_if #(
   parameter int ADDR_W = 32
) ();
   logic              req_valid;
   logic              req_ready;
   logic [4:0]        req_op;
   logic [4:0]        req_rd;
   logic [4:0]        req_rs1;
   logic [4:0]        req_rs2;
   logic [31:0]       req_imm;
   logic              imem_valid;
   logic              imem_ready;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   // Encoder side: consumes requests, masters the memory write bus
   modport master (
      input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
      output req_ready,
      output imem_valid, imem_addr, imem_wdata,
      input  imem_ready
   );

   // Environment side: issues requests, acts as the memory
   modport slave (
      output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
      input  req_ready,
      input  imem_valid, imem_addr, imem_wdata,
      output imem_ready
   );
endinterface

// File: rtl/instr_packer.sv
// instr_packer: purely combinational RV32I packer; maps a mnemonic code,
// register fields and immediate to the 32-bit instruction word and flags
// codes outside the mnemonic map as illegal.
module instr_packer
   import rv32_pkg::*;
(
   input  logic [4:0]  op_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [31:0] imm_i,
   output logic [31:0] word_o,
   output logic        illegal_o
);

   fmt_e       fmt;
   logic [6:0] opc;
   logic [6:0] f7;
   logic [2:0] f3;

   // Decode the mnemonic into format, opcode and function fields
   always_comb begin
      fmt = FMT_BAD;
      opc = 7'b0;
      f3  = 3'b0;
      f7  = F7_ZERO;
      case (op_i)
         OP_ADD:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_ADD;  end
         OP_SUB:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_ADD;  f7 = F7_ALT; end
         OP_SLL:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SLL;  end
         OP_SLT:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SLT;  end
         OP_SLTU:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SLTU; end
         OP_XOR:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_XOR;  end
         OP_SRL:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SR;   end
         OP_SRA:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SR;   f7 = F7_ALT; end
         OP_OR:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_OR;   end
         OP_AND:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_AND;  end
         OP_ADDI:  begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_ADD;  end
         OP_SLTI:  begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_SLT;  end
         OP_SLTIU: begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_SLTU; end
         OP_XORI:  begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_XOR;  end
         OP_ORI:   begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_OR;   end
         OP_ANDI:  begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_AND;  end
         OP_SLLI:  begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SLL;  end
         OP_SRLI:  begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SR;   end
         OP_SRAI:  begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SR;   f7 = F7_ALT; end
         OP_LW:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_W;    end
         OP_SW:    begin fmt = FMT_S;  opc = OPC_STORE;  f3 = F3_W;    end
         OP_BEQ:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BEQ;  end
         OP_BNE:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BNE;  end
         OP_BLT:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BLT;  end
         OP_BLTU:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BLTU; end
         OP_JAL:   begin fmt = FMT_J;  opc = OPC_JAL;    end
         OP_JALR:  begin fmt = FMT_I;  opc = OPC_JALR;   f3 = F3_ADD;  end
         OP_LUI:   begin fmt = FMT_U;  opc = OPC_LUI;    end
         OP_AUIPC: begin fmt = FMT_U;  opc = OPC_AUIPC;  end
         default:  fmt = FMT_BAD;
      endcase
   end

   // Pack the fields according to the selected format
   always_comb begin
      word_o    = 32'h0;
      illegal_o = 1'b0;
      case (fmt)
         FMT_R:  word_o = {f7, rs2_i, rs1_i, f3, rd_i, opc};
         FMT_I:  word_o = {imm_i[11:0], rs1_i, f3, rd_i, opc};
         FMT_SH: word_o = {f7, imm_i[4:0], rs1_i, f3, rd_i, opc};
         FMT_S:  word_o = {imm_i[11:5], rs2_i, rs1_i, f3, imm_i[4:0], opc};
         FMT_B:  word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3,
                           imm_i[4:1], imm_i[11], opc};
         FMT_J:  word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                           rd_i, opc};
         FMT_U:  word_o = {imm_i[31:12], rd_i, opc};
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts encode requests, packs them into RV32I words and
// writes them to consecutive instruction-memory addresses starting at
// BASE_ADDR. Optional feature macro: NOP_INSERT_EN -- when defined, one NOP
// is written ahead of an instruction that reads the rd of a directly
// preceding LW (rd != x0).
module instr_encoder
   import rv32_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          ADDR_W    = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   instr_encoder_if.master        bus,
   output logic                   err_illegal,
   output enc_state_e             dbg_state_o
);

   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

   logic [31:0]       pk_word;
   logic              pk_illegal;
   enc_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              err_q, err_d;
   logic              fire;
   logic              done;
   logic              hazard;

   instr_packer u_packer (
      .op_i      (bus.req_op),
      .rd_i      (bus.req_rd),
      .rs1_i     (bus.req_rs1),
      .rs2_i     (bus.req_rs2),
      .imm_i     (bus.req_imm),
      .word_o    (pk_word),
      .illegal_o (pk_illegal)
   );

   assign fire = bus.req_valid && bus.req_ready;
   assign done = bus.imem_valid && bus.imem_ready;

`ifdef NOP_INSERT_EN
   // Hazard history: was the last accepted instruction an LW with rd != x0
   logic       hist_lw_q, hist_lw_d;
   logic [4:0] hist_rd_q, hist_rd_d;

   assign hazard = hist_lw_q &&
                   ((op_reads_rs1(bus.req_op) && (bus.req_rs1 == hist_rd_q)) ||
                    (op_reads_rs2(bus.req_op) && (bus.req_rs2 == hist_rd_q)));

   // Hazard history register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_lw_q <= 1'b0;
         hist_rd_q <= 5'd0;
      end else begin
         hist_lw_q <= hist_lw_d;
         hist_rd_q <= hist_rd_d;
      end
   end

   // Hazard history update: record each legal accepted op, clear on flush
   always_comb begin
      hist_lw_d = hist_lw_q;
      hist_rd_d = hist_rd_q;
      if (flush) begin
         hist_lw_d = 1'b0;
         hist_rd_d = 5'd0;
      end else if (fire && !pk_illegal) begin
         hist_lw_d = (bus.req_op == OP_LW) && (bus.req_rd != 5'd0);
         hist_rd_d = bus.req_rd;
      end
   end
`else
   assign hazard = 1'b0;
`endif

   // State register with address, held word and error pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= BASE_A;
         wdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   // Next state: flush wins; completed writes advance the address
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = 1'b0;
      if (flush) begin
         state_d = ST_IDLE;
         addr_d  = BASE_A;
      end else begin
         if (done) addr_d = addr_q + ADDR_W'(4);
         if (fire) begin
            // A handshake in INSTR implies the current word completes now
            if (pk_illegal) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wdata_d = pk_word;
               state_d = hazard ? ST_NOP : ST_INSTR;
            end
         end else begin
            case (state_q)
               ST_NOP:   if (done) state_d = ST_INSTR;
               ST_INSTR: if (done) state_d = ST_IDLE;
               default:  state_d = state_q;
            endcase
         end
      end
   end

   // Outputs decoded from state; ready is also gated by reset and flush
   always_comb begin
      bus.req_ready  = !rst && !flush &&
                       ((state_q == ST_IDLE) ||
                        ((state_q == ST_INSTR) && bus.imem_ready));
      bus.imem_valid = (state_q != ST_IDLE);
      bus.imem_addr  = addr_q;
      bus.imem_wdata = (state_q == ST_NOP) ? NOP_WORD : wdata_q;
      err_illegal    = err_q;
      dbg_state_o    = state_q;
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed bench for instr_encoder with an address/data
// scoreboard on the instruction-memory write channel. Expectations adapt to
// the NOP_INSERT_EN build option.
module tb_instr_encoder;
   import rv32_pkg::*;

   localparam int ADDR_W = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       err_illegal;
   enc_state_e dbg_state;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] exp_q[$];
   logic [31:0] exp_addr;
   logic [63:0] mon_e;
   logic [31:0] hold_addr;

   instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

   instr_encoder #(.BASE_ADDR(32'h0000_0000), .ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .bus         (bus),
      .err_illegal (err_illegal),
      .dbg_state_o (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_write(input logic [31:0] word);
      exp_q.push_back({exp_addr, word});
      exp_addr += 32'd4;
   endtask

   // Present a request, wait (bounded) for ready, handshake on the next edge
   task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
      int n;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_rd    = rd;
      bus.req_rs1   = rs1;
      bus.req_rs2   = rs2;
      bus.req_imm   = imm;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_wait", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   // Wait (bounded) for the scoreboard to empty and the write bus to idle
   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.imem_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 64'(exp_q.size() == 0 && !bus.imem_valid), 64'd1);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every completed write must match the head of the queue
   always @(negedge clk) begin
      if (!rst && bus.imem_valid && bus.imem_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write_q_size", 64'(exp_q.size()), 64'd1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("imem_addr", 64'(bus.imem_addr), 64'(mon_e[63:32]));
            chk("imem_wdata", 64'(bus.imem_wdata), 64'(mon_e[31:0]));
         end
      end
   end

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_op     = 5'd0;
      bus.req_rd     = 5'd0;
      bus.req_rs1    = 5'd0;
      bus.req_rs2    = 5'd0;
      bus.req_imm    = 32'd0;
      bus.imem_ready = 1'b1;
      flush          = 1'b0;
      rst            = 1'b1;
      exp_addr       = 32'h0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_imem_valid", 64'(bus.imem_valid), 64'd0);
      chk("rst_imem_addr", 64'(bus.imem_addr), 64'h0);
      chk("rst_imem_wdata", 64'(bus.imem_wdata), 64'h0);
      chk("rst_err_illegal", 64'(err_illegal), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      @(posedge clk);
      #1 rst = 1'b0;

      // ADDI x1,x0,5; output the cycle after the handshake
      expect_write(32'h0050_0093);
      send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
      chk("first_out_valid", 64'(bus.imem_valid), 64'd1);

      // LW x2,0(x1) then ADD x3,x2,x1 back to back
      expect_write(32'h0000_A103);
`ifdef NOP_INSERT_EN
      expect_write(NOP_WORD);
`endif
      expect_write(32'h0011_01B3);
      send(OP_LW, 5'd2, 5'd1, 5'd0, 32'd0);
      send(OP_ADD, 5'd3, 5'd2, 5'd1, 32'd0);

      // Store, branch, shift-immediate, upper, jump and R-type words
      expect_write(32'h0050_A423);
      send(OP_SW, 5'd0, 5'd1, 5'd5, 32'd8);
      expect_write(32'hFE20_8EE3);
      send(OP_BEQ, 5'd0, 5'd1, 5'd2, -32'sd4);
      expect_write(32'h4031_D213);
      send(OP_SRAI, 5'd4, 5'd3, 5'd0, 32'd3);
      expect_write(32'h1234_52B7);
      send(OP_LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
      expect_write(32'h0080_00EF);
      send(OP_JAL, 5'd1, 5'd0, 5'd0, 32'd8);
      expect_write(32'h4083_8333);
      send(OP_SUB, 5'd6, 5'd7, 5'd8, 32'd0);
      drain();

      // Memory back-pressure for 3 cycles while in INSTR
      bus.imem_ready = 1'b0;
      hold_addr = exp_addr;
      expect_write(32'h4083_8333);
      send(OP_SUB, 5'd6, 5'd7, 5'd8, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid", 64'(bus.imem_valid), 64'd1);
         chk("stall_addr", 64'(bus.imem_addr), 64'(hold_addr));
         chk("stall_wdata", 64'(bus.imem_wdata), 64'h4083_8333);
         chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
      end
      @(posedge clk);
      #1 bus.imem_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_done_idle", 64'(bus.imem_valid), 64'd0);
      chk("stall_done_q", 64'(exp_q.size()), 64'd0);

      // Illegal op: error pulse, no write, address unchanged
      send(5'd30, 5'd1, 5'd1, 5'd1, 32'd0);
      chk("ill_err_pulse", 64'(err_illegal), 64'd1);
      chk("ill_no_write", 64'(bus.imem_valid), 64'd0);
      chk("ill_addr_kept", 64'(bus.imem_addr), 64'(exp_addr));
      @(posedge clk);
      #1;
      chk("ill_err_one_cycle", 64'(err_illegal), 64'd0);
      expect_write(32'h0010_0113);
      send(OP_ADDI, 5'd2, 5'd0, 5'd0, 32'd1);
      drain();

      // Flush while the LW-dependent ADD is pending (mid-NOP when enabled)
      expect_write(32'h0000_A183);
      send(OP_LW, 5'd3, 5'd1, 5'd0, 32'd0);
      send(OP_ADD, 5'd4, 5'd3, 5'd0, 32'd0);
`ifdef NOP_INSERT_EN
      chk("nop_state", 64'(dbg_state), 64'(ST_NOP));
      chk("nop_wdata", 64'(bus.imem_wdata), 64'(NOP_WORD));
`endif
      bus.imem_ready = 1'b0;
      flush          = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_op     = OP_ADDI;
      @(negedge clk);
      chk("flush_req_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1;
      flush         = 1'b0;
      bus.req_valid = 1'b0;
      chk("flush_addr", 64'(bus.imem_addr), 64'h0);
      chk("flush_valid", 64'(bus.imem_valid), 64'd0);
      chk("flush_state", 64'(dbg_state), 64'(ST_IDLE));
      bus.imem_ready = 1'b1;
      exp_addr       = 32'h0;
      // History cleared: the same ADD gets no NOP now
      expect_write(32'h0001_8233);
      send(OP_ADD, 5'd4, 5'd3, 5'd0, 32'd0);
      drain();

      // Reset in the middle of a stalled write
      bus.imem_ready = 1'b0;
      send(OP_SW, 5'd0, 5'd1, 5'd5, 32'd8);
      chk("pre_rst_valid", 64'(bus.imem_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(bus.imem_valid), 64'd0);
      chk("mid_rst_addr", 64'(bus.imem_addr), 64'h0);
      @(posedge clk);
      #1;
      rst            = 1'b0;
      bus.imem_ready = 1'b1;
      exp_addr       = 32'h0;
      expect_write(32'h0050_0093);
      send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: first instruction-memory byte address written after reset or flush.
REQ-002 Parameter ADDR_W, default 32: width of imem_addr; the address wraps modulo 2^ADDR_W.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 flush  in  1  synchronous restart of the address and hazard history.
REQ-006 req_valid  in  1  encode request present.
REQ-007 req_ready  out  1  encoder accepts the request this cycle.
REQ-008 req_op  in  5  mnemonic code from rv32_pkg (0-28 legal, 29-31 illegal).
REQ-009 req_rd / req_rs1 / req_rs2  in  5 each  register fields.
REQ-010 req_imm  in  32  signed immediate (byte offset for branch/JAL; upper 20 bits for LUI/AUIPC in imm[31:12]).
REQ-011 imem_valid  out  1  write request to instruction memory.
REQ-012 imem_ready  in  1  memory accepts the write.
REQ-013 imem_addr  out  ADDR_W  byte address.
REQ-014 imem_wdata  out  32  encoded RV32I word.
REQ-015 err_illegal  out  1  one-cycle pulse on acceptance of an illegal req_op.

Function
REQ-016 Op map: 0-9 ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND; 10-18 ADDI,SLTI,SLTIU,XORI,ORI,ANDI,SLLI,SRLI,SRAI; 19 LW; 20 SW; 21-24 BEQ,BNE,BLT,BLTU; 25 JAL; 26 JALR; 27 LUI; 28 AUIPC.
REQ-017 Encoding SHALL follow standard RV32I formats; I uses imm[11:0]; shifts use shamt=imm[4:0] with funct7 0100000 for SRAI and 0000000 otherwise; S splits imm[11:5]/imm[4:0]; B packs imm[12:1]; J packs imm[20:1]; U packs imm[31:12]; unused high imm bits are ignored.
REQ-018 FSM states: IDLE (no output), NOP (emitting 32'h0000_0013), INSTR (emitting the encoded word).
REQ-019 req_ready = (state==IDLE) || (state==INSTR && imem_ready); a handshake fires when req_valid && req_ready.
REQ-020 On a legal handshake the encoded word is registered; the next state is NOP if a hazard NOP is required, else INSTR; output appears the cycle after the handshake.
REQ-021 On an illegal handshake: no write; err_illegal pulses the next cycle; the next state is IDLE; the address is unchanged.
REQ-022 imem_valid is high in NOP and INSTR; imem_addr and imem_wdata are held stable while imem_valid && !imem_ready.
REQ-023 Each completed write (imem_valid && imem_ready) advances imem_addr by 4; NOP→INSTR on completion; INSTR→IDLE on completion with no new handshake.
REQ-024 A simultaneous INSTR completion and new handshake gives back-to-back words with no bubble.
REQ-025 flush has priority over a handshake: the current output is dropped, imem_addr is set to BASE_ADDR, the state goes to IDLE, and hazard history is cleared; req_ready is low in the flush cycle.

Reset
REQ-026 While rst is high: state IDLE, imem_valid 0, imem_addr BASE_ADDR, imem_wdata 0, err_illegal 0, req_ready 0, hazard history cleared; rst asserted mid-write abandons the write.

Configuration
REQ-027 With NOP_INSERT_EN defined: if the previously emitted instruction was LW with rd≠0 and the new instruction reads that register (rs1 for I/JALR/LW/S/B/R; rs2 for R/S/B), exactly one NOP SHALL be emitted before it.
REQ-028 Without NOP_INSERT_EN the NOP state is unreachable and no hazard tracking logic exists.

Structure
REQ-029 rv32_pkg holds the op enum, opcode/funct3/funct7 constants, and the NOP constant.
REQ-030 The combinational packing SHALL be a sub-module instr_packer (op, fields, imm → 32-bit word, illegal flag).

Verification
REQ-031 After reset, ADDI x1,x0,5 → addr 0x0 data 0x0050_0093.
REQ-032 LW x2,0(x1) then ADD x3,x2,x1 with NOP_INSERT_EN → addr 4 0x0000_A103, addr 8 0x0000_0013, addr 12 0x0011_01B3; without the macro → ADD at addr 8.
REQ-033 SW x5,8(x1) → 0x0050_A423; BEQ x1,x2,-4 → 0xFE20_8EE3.
REQ-034 imem_ready held low 3 cycles during INSTR → addr/data stable and req_ready low; the write completes on the 4th cycle.
REQ-035 req_op=30 → err_illegal pulses one cycle, no imem write, the next legal op uses the unchanged address; flush or rst mid-NOP → the next write is at BASE_ADDR.
